// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: programmable serial pattern detector with overlap mode,
// input qualification and a saturating match counter.
module seq_detect_fsm #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter bit               OVERLAP = 1'b1,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             out1,
    output logic             out2,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int P_W = $clog2(PAT_W);

    typedef enum logic {S_IDLE, S_TRACK} state_t;

    state_t           r_state, w_state_nxt;
    logic [P_W-1:0]   r_p, w_p_nxt, w_cand;
    logic [PAT_W-2:0] r_hist, w_hist_nxt;
    logic [PAT_W-1:0] r_pat, w_pat_nxt, w_win;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_out1, w_out1_nxt, w_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_hist  <= '0;
            r_pat   <= RST_PAT;
            r_cnt   <= '0;
            r_out1  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_hist  <= w_hist_nxt;
            r_pat   <= w_pat_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out1  <= w_out1_nxt;
        end
    end

    // w_win holds the newest PAT_W bits with the incoming bit in w_win[0];
    // w_cand is the longest proper prefix (<= p+1) ending at that bit, which
    // after a full match is exactly the pattern's longest border.
    always_comb begin
        w_win  = {r_hist, a};
        w_cand = '0;
        for (int k = 1; k < PAT_W; k++)
            if (k <= int'(r_p) + 1 &&
                (((r_pat >> (PAT_W - k)) ^ w_win) & ~({PAT_W{1'b1}} << k)) == '0)
                w_cand = P_W'(k);
        w_match    = (int'(r_p) == PAT_W - 1) && (w_win == r_pat);
        w_pat_nxt  = r_pat;
        w_p_nxt    = r_p;
        w_hist_nxt = r_hist;
        w_out1_nxt = 1'b0;
        if (pat_load) begin
            w_pat_nxt  = pat_in;
            w_p_nxt    = '0;
            w_hist_nxt = '0;
        end else if (in_valid) begin
            w_hist_nxt = w_win[PAT_W-2:0];
            w_out1_nxt = w_match;
            w_p_nxt    = (w_match && !OVERLAP) ? '0 : w_cand;
        end
        w_state_nxt = (w_p_nxt != '0) ? S_TRACK : S_IDLE;
        w_cnt_nxt   = cnt_clr ? '0 : (w_out1_nxt && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
    end

    assign out1      = r_out1;
    assign out2      = (r_state == S_TRACK);
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: vector and scoreboard checks of seq_detect_fsm, with extra
// instances for non-overlapping mode and a 2-bit saturating counter.
module tb_seq_detect_fsm;
    logic       clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, a = 1'b0, pat_load = 1'b0, cnt_clr = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       o1, o2, n1, n2, s1, s2;
    logic [7:0] cnt, ncnt;
    logic [1:0] scnt;
    int         n_chk = 0, n_err = 0;

    typedef struct { logic e1; logic e2; int ecnt; } exp_t;
    typedef struct { logic b; logic e1; logic e2; int ecnt; logic n1; int ncnt; } vec_t;
    exp_t sb[$];
    vec_t tbl[7];

    seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b1), .RST_PAT(4'b1011)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out1(o1), .out2(o2), .match_cnt(cnt));
    seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b0), .RST_PAT(4'b1011)) dut_nov (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out1(n1), .out2(n2), .match_cnt(ncnt));
    seq_detect_fsm #(.PAT_W(4), .CNT_W(2), .OVERLAP(1'b1), .RST_PAT(4'b1011)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .out1(s1), .out2(s2), .match_cnt(scnt));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] pin,
                        input logic clr, input logic e1, input logic e2, input int ecnt,
                        input string nm);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        a        = b;
        pat_load = ld;
        pat_in   = pin;
        cnt_clr  = clr;
        sb.push_back('{e1, e2, ecnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, ".out1"}, o1, e.e1);
        chk({nm, ".out2"}, o2, e.e2);
        chk({nm, ".cnt"}, cnt, e.ecnt);
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        logic [3:0] qs;
        logic [5:0] fs;
        logic [3:0] cs;
        qs = 4'b1011;
        fs = 6'b101011;
        cs = 4'b0110;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 2, 1'b0, 1};

        #1 rst_n = 1'b0;
        #11;
        chk("rst.out1", o1, 0);
        chk("rst.out2", o2, 0);
        chk("rst.cnt", cnt, 0);
        chk("rst.nov_out2", n2, 0);
        chk("rst.sat_cnt", scnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 0, "idle");

        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].b, 1'b0, 4'b0, 1'b0, tbl[i].e1, tbl[i].e2, tbl[i].ecnt, "ovl_stream");
            chk("nov.out1", n1, tbl[i].n1);
            chk("nov.cnt", ncnt, tbl[i].ncnt);
        end

        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 2, "load_q");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, qs[3-i], 1'b0, 4'b0, 1'b0, i == 3, 1'b1, (i == 3) ? 3 : 2, "qual");
            if (i < 3)
                for (int j = 0; j < 3; j++)
                    step(1'b0, ~qs[3-i], 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 2, "qual_idle");
        end
        step(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 3, "qual_hold");
        chk("qual.nov_cnt", ncnt, 2);
        chk("qual.sat_cnt", scnt, 3);

        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 3, "load_f");
        for (int i = 0; i < 6; i++)
            step(1'b1, fs[5-i], 1'b0, 4'b0, 1'b0, i == 5, 1'b1, (i == 5) ? 4 : 3, "fallback");
        chk("fallback.sat_out1", s1, 1);
        chk("fallback.sat_cnt", scnt, 3);
        chk("fallback.nov_cnt", ncnt, 3);

        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 4, "load_c");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 4, "pre_load");
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 4, "pre_load");
        step(1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4, "load_drop");
        for (int i = 0; i < 4; i++)
            step(1'b1, cs[3-i], 1'b0, 4'b0, 1'b0, i == 3, 1'b1, (i == 3) ? 5 : 4, "new_pat");

        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 5, "pre_clr");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 5, "pre_clr");
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b1, 1'b1, 1'b1, 0, "clr_match");
        chk("clr.sat_cnt", scnt, 0);

        for (int m = 1; m <= 5; m++) begin
            step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, m - 1, "sat_pre");
            step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, m - 1, "sat_pre");
            step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, m, "sat_match");
            chk("sat.out1", s1, 1);
            chk("sat.cnt", scnt, (m < 3) ? m : 3);
        end

        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 5, "load_b2b");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, i >= 3, 1'b1, (i >= 3) ? i + 3 : 5, "b2b");

        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 7, "load_r");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 7, "pre_rst");
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 7, "pre_rst");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 7, "pre_rst");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.out1", o1, 0);
        chk("arst.out2", o2, 0);
        chk("arst.cnt", cnt, 0);
        chk("arst.nov_out2", n2, 0);
        chk("arst.sat_out2", s2, 0);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 0, "post_rst");
        step(1'b1, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 0, "post_rst");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 0, "post_rst");
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, 1, "post_rst_match");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
